// File: rtl/qpsk_pkg.sv
// Shared constants and sizing helpers for the QPSK TX/RX chain.
package qpsk_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam int DEF_CLK_DIV     = 2;
  localparam int DEF_OVERSAMPLE  = 4;
  localparam int DEF_FLUSH_LEN   = 24;
  localparam int DEF_SYNC_STAGES = 2;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int phase_w(input int oversample);
    return cnt_w(oversample);
  endfunction

endpackage

// File: rtl/sync_bits.sv
// Multi-flop synchronizer for slow asynchronous level inputs (no debounce).
module sync_bits #(
  parameter int WIDTH  = 2,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/qpsk_tx_sequencer.sv
// Timing and mode controller for the QPSK chain: sample/symbol enables,
// oversampling phase and the IDLE -> FLUSH -> RUN start-up sequence.
module qpsk_tx_sequencer
  import qpsk_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int FLUSH_LEN   = DEF_FLUSH_LEN,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                             CLK100MHZ,
  input  logic                             rst,
  input  logic [1:0]                       i_switch,
  output logic                             o_en_tx,
  output logic                             o_en_prbs,
  output logic                             o_en_rx,
  output logic [phase_w(OVERSAMPLE)-1:0]   o_phase,
  output logic                             o_flush,
  output logic                             o_run
);

  localparam int DIV_W   = cnt_w(CLK_DIV);
  localparam int PHASE_W = phase_w(OVERSAMPLE);
  localparam int FC_W    = cnt_w(FLUSH_LEN + 1);

  logic [1:0]         sw_s;
  logic [DIV_W-1:0]   div_cnt;
  logic [PHASE_W-1:0] phase;
  logic [FC_W-1:0]    flush_cnt, flush_cnt_nxt;
  logic [1:0]         state, state_nxt;
  logic               tick, sym, flush_done;

  sync_bits #(
    .WIDTH  (2),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (CLK100MHZ),
    .rst_n (rst),
    .d     (i_switch),
    .q     (sw_s)
  );

  assign tick       = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign sym        = tick && (phase == PHASE_W'(OVERSAMPLE - 1));
  assign flush_done = (flush_cnt == FC_W'(FLUSH_LEN));

  // Divider and phase free-run regardless of state so RUN entry stays phase-aligned.
  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      phase   <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        phase <= phase + PHASE_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      ST_IDLE: begin
        if (sw_s[0]) begin
          state_nxt     = ST_FLUSH;
          flush_cnt_nxt = '0;
        end
      end
      ST_FLUSH: begin
        if (tick && !flush_done) begin
          flush_cnt_nxt = flush_cnt + FC_W'(1);
        end
        if (flush_done && sym) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // Dropping the TX switch wins over every other transition.
    if (!sw_s[0]) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Registered outputs: each reflects the previous cycle's state and counters.
  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      o_en_tx   <= 1'b0;
      o_en_prbs <= 1'b0;
      o_en_rx   <= 1'b0;
      o_phase   <= '0;
      o_flush   <= 1'b0;
      o_run     <= 1'b0;
    end else begin
      o_en_tx   <= tick && (state != ST_IDLE);
      o_en_prbs <= sym && (state == ST_RUN);
      o_en_rx   <= tick && (state == ST_RUN) && sw_s[1];
      o_phase   <= phase;
      o_flush   <= (state == ST_FLUSH);
      o_run     <= (state == ST_RUN);
    end
  end

endmodule

// File: tb/tb_qpsk_tx_sequencer.sv
// Directed bench for qpsk_tx_sequencer: default build plus a minimal-parameter build.
module tb_qpsk_tx_sequencer;

  logic       clk;
  logic       rst, rst2;
  logic [1:0] sw, sw2;

  logic       en_tx, en_prbs, en_rx, flush, run;
  logic [1:0] phase;
  logic       en_tx2, en_prbs2, en_rx2, flush2, run2;
  logic [0:0] phase2;

  logic [6:0] v1;
  logic [5:0] v2;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  assign v1 = {run, flush, en_rx, en_prbs, en_tx, phase};
  assign v2 = {run2, flush2, en_rx2, en_prbs2, en_tx2, phase2};

  qpsk_tx_sequencer dut (
    .CLK100MHZ (clk),
    .rst       (rst),
    .i_switch  (sw),
    .o_en_tx   (en_tx),
    .o_en_prbs (en_prbs),
    .o_en_rx   (en_rx),
    .o_phase   (phase),
    .o_flush   (flush),
    .o_run     (run)
  );

  qpsk_tx_sequencer #(
    .CLK_DIV    (1),
    .OVERSAMPLE (2),
    .FLUSH_LEN  (1)
  ) dut2 (
    .CLK100MHZ (clk),
    .rst       (rst2),
    .i_switch  (sw2),
    .o_en_tx   (en_tx2),
    .o_en_prbs (en_prbs2),
    .o_en_rx   (en_rx2),
    .o_phase   (phase2),
    .o_flush   (flush2),
    .o_run     (run2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land on the following falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    rst2 = 1'b0;
    sw   = 2'b11;
    sw2  = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total_cnt++;
      if (v1 !== 7'd0) $display("FAIL reset_hold i=%0d got=%b want=%b", i, v1, 7'd0);
      else pass_cnt++;
    end
    rst = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      total_cnt++;
      if (flush !== (cyc == 4)) $display("FAIL idle_after_release cyc=%0d got=%b want=%b", cyc, flush, (cyc == 4));
      else pass_cnt++;
    end
  endtask

  task automatic test_flush_run();
    logic [6:0] e;
    while (cyc < 80) begin
      step();
      e[1:0] = 2'(((cyc - 1) / 2) % 4);
      e[2]   = (cyc % 2 == 0) && (cyc >= 4);
      e[3]   = (cyc >= 64) && (cyc % 8 == 0);
      e[4]   = (cyc % 2 == 0) && (cyc >= 58);
      e[5]   = (cyc >= 4) && (cyc <= 56);
      e[6]   = (cyc >= 57);
      total_cnt++;
      if (v1 !== e) $display("FAIL flush_run cyc=%0d got=%b want=%b", cyc, v1, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_rx_gate();
    logic [6:0] e;
    sw = 2'b01;
    while (cyc < 100) begin
      step();
      e[1:0] = 2'(((cyc - 1) / 2) % 4);
      e[2]   = (cyc % 2 == 0);
      e[3]   = (cyc % 8 == 0);
      e[4]   = (cyc == 82);
      e[5]   = 1'b0;
      e[6]   = 1'b1;
      total_cnt++;
      if (v1 !== e) $display("FAIL rx_gate cyc=%0d got=%b want=%b", cyc, v1, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_tx_drop();
    logic [6:0] e;
    sw = 2'b00;
    while (cyc < 115) begin
      step();
      e[1:0] = 2'(((cyc - 1) / 2) % 4);
      e[2]   = (cyc == 102);
      e[3]   = 1'b0;
      e[4]   = 1'b0;
      e[5]   = 1'b0;
      e[6]   = (cyc <= 103);
      total_cnt++;
      if (v1 !== e) $display("FAIL tx_drop cyc=%0d got=%b want=%b", cyc, v1, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_flush_abort();
    int early = 0;
    int ticks = 0;
    while (cyc < 209) begin
      if (cyc == 116) sw = 2'b11;
      if (cyc == 136) sw = 2'b10;
      if (cyc == 150) sw = 2'b11;
      step();
      if (cyc == 139) begin
        total_cnt++;
        if (flush !== 1'b1) $display("FAIL abort_flush_held got=%b want=1", flush);
        else pass_cnt++;
      end
      if (cyc == 140) begin
        total_cnt++;
        if (flush !== 1'b0) $display("FAIL abort_flush_drop got=%b want=0", flush);
        else pass_cnt++;
      end
      if (cyc < 209 && run) early++;
      if (cyc >= 151 && en_tx && flush) ticks++;
    end
    total_cnt++;
    if (early !== 0) $display("FAIL abort_run_early got=%0d cycles want=0", early);
    else pass_cnt++;
    total_cnt++;
    if (run !== 1'b1) $display("FAIL abort_run_rise got=%b want=1", run);
    else pass_cnt++;
    total_cnt++;
    if (ticks !== 28) $display("FAIL abort_reflush_ticks got=%0d want=28", ticks);
    else pass_cnt++;
  endtask

  task automatic test_small_cfg();
    logic [5:0] e;
    sw2  = 2'b11;
    rst2 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      e[0] = 1'((c - 1) % 2);
      e[1] = (c >= 4);
      e[2] = (c >= 8) && (c % 2 == 0);
      e[3] = (c >= 7);
      e[4] = (c >= 4) && (c <= 6);
      e[5] = (c >= 7);
      total_cnt++;
      if (v2 !== e) $display("FAIL small_cfg c=%0d got=%b want=%b", c, v2, e);
      else pass_cnt++;
    end
    #2 rst2 = 1'b0;
    #1;
    total_cnt++;
    if (v2 !== 6'd0) $display("FAIL async_reset_now got=%b want=%b", v2, 6'd0);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (v2 !== 6'd0) $display("FAIL async_reset_held got=%b want=%b", v2, 6'd0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_flush_run();
    test_rx_gate();
    test_tx_drop();
    test_flush_abort();
    test_small_cfg();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/qpsk_tx_sequencer.md
Name: qpsk_tx_sequencer

Overview:
- Central timing and mode controller for the QPSK transmit/receive chain, instantiated in top_level next to the PRBS, TX filter and RX blocks.
- Derives the TX-rate clock enable and the symbol-rate PRBS enable from CLK100MHZ, and exposes the current oversampling phase.
- Sequences datapath start-up from the synchronized i_switch inputs (IDLE -> FLUSH -> RUN) so the filter is flushed and symbols start phase-aligned.

Parameters:
CLK_DIV, 2, CLK100MHZ cycles per TX sample tick (>=1)
OVERSAMPLE, 4, TX sample ticks per symbol (power of 2, >=2)
FLUSH_LEN, 24, minimum TX ticks spent in FLUSH (>=1)
SYNC_STAGES, 2, flops in the i_switch synchronizer (>=2)

Ports:
CLK100MHZ  in  1  system clock
rst  in  1  asynchronous reset, active-low
i_switch  in  2  [0]=TX enable, [1]=RX enable; asynchronous board switches
o_en_tx  out  1  1-cycle TX sample-rate enable
o_en_prbs  out  1  1-cycle symbol-rate enable to the PRBS
o_en_rx  out  1  1-cycle RX sample-rate enable
o_phase  out  log2(OVERSAMPLE)  current oversampling phase
o_flush  out  1  high while in FLUSH; datapath zero-stuffs its input
o_run  out  1  high while in RUN

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; div_cnt, phase, flush_cnt and sync flops = 0; all outputs = 0.
- Synchronizer: each i_switch bit passes through SYNC_STAGES flops. sw_s = last stage. No debounce.
- div_cnt counts 0..CLK_DIV-1 and wraps. It free-runs in every state. tick = (div_cnt==CLK_DIV-1).
- phase advances by 1 mod OVERSAMPLE on each tick and free-runs in every state. sym = tick & (phase==OVERSAMPLE-1).
- FSM, evaluated every cycle; all transitions take effect on the next edge:
  - IDLE: if sw_s[0]=1, go to FLUSH and clear flush_cnt.
  - FLUSH: flush_cnt increments on each tick and saturates at FLUSH_LEN. When flush_cnt==FLUSH_LEN and sym, go to RUN. The first RUN tick is therefore phase 0.
  - RUN: stays in RUN while sw_s[0]=1.
  - In any state, sw_s[0]=0 forces IDLE next cycle. This overrides every other transition.
- Outputs are registered: each is updated on the edge from the current-cycle state and counters, so it lags its cause by 1 cycle.
  - o_en_tx = tick & (state!=IDLE)
  - o_en_prbs = sym & (state==RUN)
  - o_en_rx = tick & (state==RUN) & sw_s[1]
  - o_phase = phase
  - o_flush = (state==FLUSH)
  - o_run = (state==RUN)
- CLK_DIV=1: tick is constant 1 and o_en_tx is high on every cycle while active.
- Switch dropped mid-FLUSH: the block goes to IDLE and flush_cnt is discarded. Re-assertion starts a full new flush.
- sw_s[1] toggling in RUN gates o_en_rx only. The FSM is unaffected.
- Reset mid-RUN: all outputs drop to 0 asynchronously. After release the block starts from IDLE.

Decomposition:
- Shared package qpsk_pkg holds:
  - state encoding: ST_IDLE=2'd0, ST_FLUSH=2'd1, ST_RUN=2'd2
  - PHASE_W = clog2(OVERSAMPLE) helper
  - default CLK_DIV, OVERSAMPLE and FLUSH_LEN constants, shared with the PRBS and filter blocks
- Sub-module sync_bits: parameterized width and stage count, reset to 0. Also reusable by the RX side.

Test Plan (defaults unless stated):
1. Reset held low for 8 cycles with i_switch=11 -> all outputs 0 throughout; after release the FSM stays in IDLE for SYNC_STAGES+1 cycles.
2. i_switch=11 from reset -> o_flush rises. o_en_tx pulses every 2 cycles with o_en_prbs=0. After >=24 ticks, o_run rises on the tick where o_phase goes 3->0. o_en_prbs then pulses every 8 cycles, coincident with o_en_tx when o_phase=3. o_en_rx equals o_en_tx.
3. In RUN, i_switch[1]=0 -> within SYNC_STAGES+1 cycles o_en_rx stays 0. o_en_tx and o_en_prbs are unchanged and o_run stays 1.
4. In RUN, i_switch[0]=0 -> o_run, o_en_tx and o_en_prbs all go to 0 within SYNC_STAGES+2 cycles. o_phase keeps counting.
5. i_switch[0] dropped after 10 FLUSH ticks, then re-asserted -> a new FLUSH of >=24 ticks is required before o_run rises (count ticks).
6. CLK_DIV=1, OVERSAMPLE=2, FLUSH_LEN=1 -> o_en_tx is constant 1 while active, and o_en_prbs pulses every 2 cycles in RUN. Async reset asserted mid-RUN forces all outputs to 0 on the same cycle, without waiting for a clock edge.
